cpu_mc: RTL and testbench
=========================

// Module: cpu_mc
// PURPOSE
//  Multicycle RV32I core replacing the fixed fetch/execute loop with a sequenced FETCH/EXEC/MEM flow.
//  Instruction fetch and data access use valid/ready buses with wait states, so memories and MMIO
//  (e.g. the fifo_if bridge) can stall the core. Adds loads/stores, branches, jumps, halt/trap.
//  Sits under the SoC top in place of the inline datapath; the memory/MMIO decoder sits outside.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NUM_REGS   32             register count: 32 (RV32I) or 16 (RV32E; rd/rs index >=16 is illegal)
//  HALT_ILL   1              1: illegal/misaligned -> HALT; 0: treat as NOP, set trap_o pulse only
// PORTS
//  clk_i          in   1   clock
//  rstn_i         in   1   async active-low reset
//  ibus_valid_o   out  1   fetch request; addr held until ibus_ready_i
//  ibus_addr_o    out  32  fetch address (= pc, word aligned)
//  ibus_ready_i   in   1   fetch accept; ibus_rdata_i valid in the same cycle
//  ibus_rdata_i   in   32  instruction word
//  dbus_valid_o   out  1   data request; all dbus_* outputs held until dbus_ready_i
//  dbus_we_o      out  1   1 = store, 0 = load
//  dbus_addr_o    out  32  byte address (natural alignment)
//  dbus_be_o      out  4   byte enables (stores; loads drive the bytes actually read)
//  dbus_wdata_o   out  32  store data, lane-replicated (SB: {4{b}}, SH: {2{h}})
//  dbus_ready_i   in   1   data accept; dbus_rdata_i valid same cycle for loads
//  dbus_rdata_i   in   32  load data (full word; core extracts lane)
//  retire_o       out  1   1-cycle pulse per retired instruction
//  trap_o         out  1   1-cycle pulse on illegal opcode or misaligned access/target
//  halt_o         out  1   level, high in HALT (EBREAK/ECALL, or trap with HALT_ILL=1)
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, regs=0, all outputs 0 except ibus_addr_o=RESET_PC.
//   ibus_valid_o rises the first cycle after rstn_i deasserts.
//  FETCH: ibus_valid_o=1, addr=pc; on valid&&ready latch instr -> EXEC. Valid never drops before ready.
//  EXEC (1 cycle): decode + ALU. ALU/LUI/AUIPC/JAL/JALR/branch: write rd, pc<=next, retire_o=1 -> FETCH.
//   LOAD/STORE: compute addr; aligned -> MEM; misaligned -> trap path.
//   EBREAK/ECALL: retire_o=1, -> HALT. FENCE: NOP.
//  MEM: drive dbus_*; on handshake: load writes rd (LB/LH sign-extend, LBU/LHU zero-extend),
//   pc<=pc+4, retire_o=1 -> FETCH.
//  HALT: absorbing; only reset exits. Bus valids 0.
//  Latency with zero-wait buses: 2 cycles/instr (3 for load/store); each wait cycle adds 1.
//  Arithmetic: 32-bit modulo; pc+4 and branch targets wrap at 2^32. Shifts use low 5 bits of rs2/shamt.
//  JALR target: (rs1+imm) & ~1. Taken branch/jump target with bit1 set -> trap, rd not written.
//  x0: reads 0, writes discarded (JAL x0 must not corrupt it).
//  rd==rs1 (e.g. addi x1,x1,1; jalr x1,0(x1)): operands sampled before write; uses old value.
//  Trap, HALT_ILL=1: trap_o=1 -> HALT, no retire. HALT_ILL=0: trap_o=1, retire_o=1, pc+4, no side effects.
//  Reset mid-transaction: valids drop asynchronously; bus slaves must discard partial handshakes.
//  Exactly one instruction in flight; no outstanding requests across states.
// STRUCTURE
//  Shared package: opcode/funct3 localparams, state enum {FETCH,EXEC,MEM,HALT}, ALU op codes,
//   reset PC default. Decode is combinational and self-contained -> sub-module rv_decode
//   (instr -> rd/rs1/rs2 idx, imm, alu op, class, illegal). Regfile and ALU stay inline.
// TESTING
//  addi x1,x0,5; addi x2,x1,-7; zero-wait -> x2=0xFFFFFFFE, retire every 2 cycles.
//  lui x3,0x12345; sw x3,4(x0) with 3 wait cycles -> dbus addr=4, be=4'hF, wdata=0x12345000; 6 cycles.
//  sb x3(byte 0x80),1(x0); lb x4,1(x0) rdata=0x0000_8000 -> be=4'b0010, wdata=0x80808080, x4=0xFFFFFF80.
//  bne x0,x1 backward -8 at pc=0x10 -> next ibus_addr_o=0x08; beq not taken -> 0x14.
//  lw at addr 0x2 -> trap_o pulse, halt_o=1, no dbus_valid_o; HALT_ILL=0 -> pc advances, x rd unchanged.
//  Assert rstn_i low while ibus stalled in FETCH -> ibus_valid_o=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/cpu_mc_pkg.sv
// Shared types and constants for the multicycle RV32I core.
// Opcodes, FSM states, ALU ops and the decoded-instruction bundle.
package cpu_mc_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_FENCE = 7'h0F;
  localparam logic [6:0] OP_SYS   = 7'h73;

  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_FETCH, S_EXEC, S_MEM, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR,
    A_SRL, A_SRA, A_OR, A_AND, A_PASSB
  } alu_e;

  typedef enum logic [2:0] {
    C_ALU, C_JAL, C_JALR, C_BR,
    C_LOAD, C_STORE, C_NOP, C_HALT
  } cls_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    alu_e        alu;
    cls_e        cls;
    logic        a_pc;
    logic        b_imm;
    logic        illegal;
  } dec_t;

  function automatic alu_e alu_of(input logic [2:0] f3,
                                  input logic alt);
    alu_e op;
    case (f3)
      3'd0:    op = alt ? A_SUB : A_ADD;
      3'd1:    op = A_SLL;
      3'd2:    op = A_SLT;
      3'd3:    op = A_SLTU;
      3'd4:    op = A_XOR;
      3'd5:    op = alt ? A_SRA : A_SRL;
      3'd6:    op = A_OR;
      default: op = A_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_mc_rv_decode.sv
// Combinational RV32I/RV32E instruction decoder.
// Produces register indices, immediate, ALU op, class and illegal flag.
import cpu_mc_pkg::*;

module rv_decode #(
  parameter int NUM_REGS = 32
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       u_rd;
  logic       u_rs1;
  logic       u_rs2;
  logic       bad;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  always_comb begin
    dec       = '0;
    dec.rd    = instr[11:7];
    dec.rs1   = instr[19:15];
    dec.rs2   = instr[24:20];
    dec.f3    = f3;
    dec.imm   = {{20{instr[31]}}, instr[31:20]};
    dec.alu   = A_ADD;
    dec.cls   = C_ALU;
    u_rd      = 1'b1;
    u_rs1     = 1'b0;
    u_rs2     = 1'b0;
    bad       = 1'b0;
    case (op)
      OP_LUI: begin
        dec.imm   = {instr[31:12], 12'd0};
        dec.b_imm = 1'b1;
        dec.alu   = A_PASSB;
      end
      OP_AUIPC: begin
        dec.imm   = {instr[31:12], 12'd0};
        dec.a_pc  = 1'b1;
        dec.b_imm = 1'b1;
      end
      OP_JAL: begin
        dec.cls = C_JAL;
        dec.imm = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.cls = C_JALR;
        u_rs1   = 1'b1;
        bad     = (f3 != 3'd0);
      end
      OP_BR: begin
        dec.cls = C_BR;
        dec.imm = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
        u_rd    = 1'b0;
        u_rs1   = 1'b1;
        u_rs2   = 1'b1;
        bad     = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_LOAD: begin
        dec.cls = C_LOAD;
        u_rs1   = 1'b1;
        bad     = (f3 == 3'd3) || (f3 > 3'd5);
      end
      OP_STORE: begin
        dec.cls = C_STORE;
        dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        u_rd    = 1'b0;
        u_rs1   = 1'b1;
        u_rs2   = 1'b1;
        bad     = (f3 > 3'd2);
      end
      OP_IMM: begin
        dec.b_imm = 1'b1;
        dec.alu   = alu_of(f3, (f3 == 3'd5) && f7[5]);
        u_rs1     = 1'b1;
        if (f3 == 3'd1)
          bad = (f7 != 7'h00);
        else if (f3 == 3'd5)
          bad = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OP_REG: begin
        dec.alu = alu_of(f3, f7[5]);
        u_rs1   = 1'b1;
        u_rs2   = 1'b1;
        bad     = !((f7 == 7'h00) ||
                    ((f7 == 7'h20) &&
                     ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OP_FENCE: begin
        dec.cls = C_NOP;
        u_rd    = 1'b0;
      end
      OP_SYS: begin
        dec.cls = C_HALT;
        u_rd    = 1'b0;
        bad     = (instr != I_ECALL) && (instr != I_EBREAK);
      end
      default: bad = 1'b1;
    endcase
    // RV32E only has x0..x15; any live index above that is illegal
    if (NUM_REGS == 16)
      bad = bad || (u_rd && dec.rd[4]) ||
            (u_rs1 && dec.rs1[4]) || (u_rs2 && dec.rs2[4]);
    dec.illegal = bad;
  end

endmodule

// File: rtl/cpu_mc.sv
// Multicycle RV32I core: FETCH -> EXEC -> (MEM) over valid/ready buses.
// One instruction in flight; bus outputs are held until the handshake.
import cpu_mc_pkg::*;

module cpu_mc #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          NUM_REGS = 32,
  parameter bit          HALT_ILL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        ibus_valid_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ready_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        dbus_valid_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ready_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        retire_o,
  output logic        trap_o,
  output logic        halt_o
);

  localparam int RW = $clog2(NUM_REGS);

  state_e      state;
  logic [31:0] pc, instr_q;
  logic [31:0] rf [NUM_REGS];
  logic        ivld_q, dvld_q, dwe_q;
  logic [31:0] daddr_q, dwd_q;
  logic [3:0]  dbe_q;
  logic        retire_q, trap_q, halt_q;

  dec_t        dec;
  logic [31:0] rs1v, rs2v, alu_a, alu_b, alu_y;
  logic [31:0] pc4, tgt, maddr, wd, wr_val, lsh, ld_val;
  logic [3:0]  be;
  logic        br, taken, is_mem, mis, trap, wr_en;

  rv_decode #(.NUM_REGS(NUM_REGS)) u_dec (
    .instr (instr_q),
    .dec   (dec)
  );

  assign rs1v = (dec.rs1 == 5'd0) ? '0 : rf[dec.rs1[RW-1:0]];
  assign rs2v = (dec.rs2 == 5'd0) ? '0 : rf[dec.rs2[RW-1:0]];

  always_comb begin
    alu_a = dec.a_pc ? pc : rs1v;
    alu_b = dec.b_imm ? dec.imm : rs2v;
    case (dec.alu)
      A_SUB:   alu_y = alu_a - alu_b;
      A_SLL:   alu_y = alu_a << alu_b[4:0];
      A_SLT:   alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      A_SLTU:  alu_y = {31'd0, alu_a < alu_b};
      A_XOR:   alu_y = alu_a ^ alu_b;
      A_SRL:   alu_y = alu_a >> alu_b[4:0];
      A_SRA:   alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      A_OR:    alu_y = alu_a | alu_b;
      A_AND:   alu_y = alu_a & alu_b;
      A_PASSB: alu_y = alu_b;
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_comb begin
    case (dec.f3)
      3'd0:    br = (rs1v == rs2v);
      3'd1:    br = (rs1v != rs2v);
      3'd4:    br = ($signed(rs1v) < $signed(rs2v));
      3'd5:    br = ($signed(rs1v) >= $signed(rs2v));
      3'd6:    br = (rs1v < rs2v);
      3'd7:    br = (rs1v >= rs2v);
      default: br = 1'b0;
    endcase
  end

  assign pc4    = pc + 32'd4;
  assign maddr  = rs1v + dec.imm;
  assign tgt    = (dec.cls == C_JALR) ? (maddr & ~32'd1)
                                      : (pc + dec.imm);
  assign taken  = (dec.cls == C_JAL) || (dec.cls == C_JALR) ||
                  ((dec.cls == C_BR) && br);
  assign is_mem = (dec.cls == C_LOAD) || (dec.cls == C_STORE);

  always_comb begin
    case (dec.f3[1:0])
      2'd0: begin
        mis = 1'b0;
        be  = 4'b0001 << maddr[1:0];
        wd  = {4{rs2v[7:0]}};
      end
      2'd1: begin
        mis = maddr[0];
        be  = maddr[1] ? 4'b1100 : 4'b0011;
        wd  = {2{rs2v[15:0]}};
      end
      default: begin
        mis = |maddr[1:0];
        be  = 4'hF;
        wd  = rs2v;
      end
    endcase
  end

  // A taken target with bit1 set is a misaligned fetch: trap, no link
  assign trap   = dec.illegal || (is_mem && mis) ||
                  (taken && tgt[1]);
  assign wr_val = ((dec.cls == C_JAL) || (dec.cls == C_JALR))
                  ? pc4 : alu_y;
  assign wr_en  = !trap && (dec.rd != 5'd0) &&
                  ((dec.cls == C_ALU) || (dec.cls == C_JAL) ||
                   (dec.cls == C_JALR));

  assign lsh = dbus_rdata_i >> {daddr_q[1:0], 3'b000};

  always_comb begin
    case (dec.f3)
      3'd0:    ld_val = {{24{lsh[7]}}, lsh[7:0]};
      3'd1:    ld_val = {{16{lsh[15]}}, lsh[15:0]};
      3'd4:    ld_val = {24'd0, lsh[7:0]};
      3'd5:    ld_val = {16'd0, lsh[15:0]};
      default: ld_val = lsh;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      instr_q  <= '0;
      ivld_q   <= 1'b0;
      dvld_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dbe_q    <= '0;
      dwd_q    <= '0;
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
      halt_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
      unique case (state)
        S_FETCH: begin
          ivld_q <= 1'b1;
          if (ivld_q && ibus_ready_i) begin
            ivld_q  <= 1'b0;
            instr_q <= ibus_rdata_i;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (trap) begin
            trap_q <= 1'b1;
            if (HALT_ILL) begin
              halt_q <= 1'b1;
              state  <= S_HALT;
            end else begin
              retire_q <= 1'b1;
              pc       <= pc4;
              ivld_q   <= 1'b1;
              state    <= S_FETCH;
            end
          end else if (dec.cls == C_HALT) begin
            retire_q <= 1'b1;
            halt_q   <= 1'b1;
            state    <= S_HALT;
          end else if (is_mem) begin
            dvld_q  <= 1'b1;
            dwe_q   <= (dec.cls == C_STORE);
            daddr_q <= maddr;
            dbe_q   <= be;
            dwd_q   <= wd;
            state   <= S_MEM;
          end else begin
            if (wr_en)
              rf[dec.rd[RW-1:0]] <= wr_val;
            pc       <= taken ? tgt : pc4;
            retire_q <= 1'b1;
            ivld_q   <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dbus_ready_i) begin
            dvld_q <= 1'b0;
            if (!dwe_q && (dec.rd != 5'd0))
              rf[dec.rd[RW-1:0]] <= ld_val;
            pc       <= pc4;
            retire_q <= 1'b1;
            ivld_q   <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_HALT: begin
        end
      endcase
    end
  end

  assign ibus_valid_o = ivld_q;
  assign ibus_addr_o  = pc;
  assign dbus_valid_o = dvld_q;
  assign dbus_we_o    = dwe_q;
  assign dbus_addr_o  = daddr_q;
  assign dbus_be_o    = dbe_q;
  assign dbus_wdata_o = dwd_q;
  assign retire_o     = retire_q;
  assign trap_o       = trap_q;
  assign halt_o       = halt_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: two cores (HALT_ILL=1 / 0) share one program
// image; bus slaves with configurable wait states log every handshake.
module tb_cpu_mc;

  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  ivld, irdy, dvld, dwe, drdy, ret, trp, hlt;
  logic [31:0] iaddr [2];
  logic [31:0] irdata [2];
  logic [31:0] daddr [2];
  logic [31:0] dwdata [2];
  logic [3:0]  dbe [2];
  logic [31:0] drdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int iwait = 0;
  int dwait = 0;
  logic [31:0] imem [64];
  logic [31:0] fa [2][32];
  logic [31:0] da [2][8];
  logic [31:0] dw [2][8];
  logic [3:0]  db [2][8];
  logic        dwr [2][8];
  int fn [2];
  int dn [2];
  int rc [2];
  int tc [2];
  int ic [2];
  int dc [2];
  int rcyc [2][32];

  always #5 clk = ~clk;

  cpu_mc #(.HALT_ILL(1'b1)) dut0 (
    .clk_i(clk), .rstn_i(rstn),
    .ibus_valid_o(ivld[0]), .ibus_addr_o(iaddr[0]),
    .ibus_ready_i(irdy[0]), .ibus_rdata_i(irdata[0]),
    .dbus_valid_o(dvld[0]), .dbus_we_o(dwe[0]),
    .dbus_addr_o(daddr[0]), .dbus_be_o(dbe[0]),
    .dbus_wdata_o(dwdata[0]), .dbus_ready_i(drdy[0]),
    .dbus_rdata_i(drdata), .retire_o(ret[0]),
    .trap_o(trp[0]), .halt_o(hlt[0])
  );

  cpu_mc #(.HALT_ILL(1'b0)) dut1 (
    .clk_i(clk), .rstn_i(rstn),
    .ibus_valid_o(ivld[1]), .ibus_addr_o(iaddr[1]),
    .ibus_ready_i(irdy[1]), .ibus_rdata_i(irdata[1]),
    .dbus_valid_o(dvld[1]), .dbus_we_o(dwe[1]),
    .dbus_addr_o(daddr[1]), .dbus_be_o(dbe[1]),
    .dbus_wdata_o(dwdata[1]), .dbus_ready_i(drdy[1]),
    .dbus_rdata_i(drdata), .retire_o(ret[1]),
    .trap_o(trp[1]), .halt_o(hlt[1])
  );

  function automatic logic [31:0] e_i(input logic [31:0] imm,
      input logic [31:0] rs1, input logic [31:0] f3,
      input logic [31:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] e_s(input logic [31:0] imm,
      input logic [31:0] rs2, input logic [31:0] rs1,
      input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_b(input logic [31:0] imm,
      input logic [31:0] rs2, input logic [31:0] rs1,
      input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_j(input logic [31:0] imm,
      input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (ret[i]) begin
        if (rc[i] < 32) rcyc[i][rc[i]] = cyc;
        rc[i]++;
      end
      if (trp[i]) tc[i]++;
      irdy[i] = 1'b0;
      if (ivld[i]) begin
        if (ic[i] >= iwait) begin
          irdy[i] = 1'b1;
          irdata[i] = imem[iaddr[i][7:2]];
          if (fn[i] < 32) fa[i][fn[i]] = iaddr[i];
          fn[i]++;
          ic[i] = 0;
        end else ic[i]++;
      end else ic[i] = 0;
      drdy[i] = 1'b0;
      if (dvld[i]) begin
        if (dc[i] >= dwait) begin
          drdy[i] = 1'b1;
          if (dn[i] < 8) begin
            da[i][dn[i]] = daddr[i];
            dw[i][dn[i]] = dwdata[i];
            db[i][dn[i]] = dbe[i];
            dwr[i][dn[i]] = dwe[i];
          end
          dn[i]++;
          dc[i] = 0;
        end else dc[i]++;
      end else dc[i] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 64; k++) imem[k] = EBRK;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    iwait = 0;
    dwait = 0;
    for (int i = 0; i < 2; i++) begin
      fn[i] = 0; dn[i] = 0; rc[i] = 0; tc[i] = 0; ic[i] = 0; dc[i] = 0;
    end
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    clear_prog();
    irdy = '0; drdy = '0; drdata = '0;
    irdata[0] = '0; irdata[1] = '0;
    rstn = 1'b0;
    step();
    total++; if (ivld[0] !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b exp=0", ivld[0]); end
    total++; if (iaddr[0] !== 32'h0) begin bad++; $display("FAIL rst_iaddr got=%h exp=0", iaddr[0]); end
    total++; if (dvld[0] !== 1'b0) begin bad++; $display("FAIL rst_dvalid got=%b exp=0", dvld[0]); end
    total++; if (ret[0] !== 1'b0) begin bad++; $display("FAIL rst_retire got=%b exp=0", ret[0]); end
    total++; if (trp[0] !== 1'b0) begin bad++; $display("FAIL rst_trap got=%b exp=0", trp[0]); end
    total++; if (hlt[0] !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b exp=0", hlt[0]); end
    do_reset();
    total++; if (ivld[0] !== 1'b0) begin bad++; $display("FAIL rel_ivalid0 got=%b exp=0", ivld[0]); end
    step();
    total++; if (ivld[0] !== 1'b1) begin bad++; $display("FAIL rel_ivalid1 got=%b exp=1", ivld[0]); end
  endtask

  task automatic test_alu();
    clear_prog();
    imem[0] = e_i(5, 0, 0, 1, 7'h13);
    imem[1] = e_i(-7, 1, 0, 2, 7'h13);
    imem[2] = e_s(0, 2, 0, 2);
    do_reset();
    run(30);
    total++; if (dn[0] !== 1) begin bad++; $display("FAIL alu_ntx got=%0d exp=1", dn[0]); end
    total++; if (dw[0][0] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL alu_x2 got=%h exp=fffffffe", dw[0][0]); end
    total++; if (da[0][0] !== 32'h0) begin bad++; $display("FAIL alu_addr got=%h exp=0", da[0][0]); end
    total++; if (rcyc[0][1] - rcyc[0][0] !== 2) begin bad++; $display("FAIL alu_gap got=%0d exp=2", rcyc[0][1] - rcyc[0][0]); end
    total++; if (rc[0] !== 4) begin bad++; $display("FAIL alu_retires got=%0d exp=4", rc[0]); end
    total++; if (hlt[0] !== 1'b1) begin bad++; $display("FAIL alu_halt got=%b exp=1", hlt[0]); end
    total++; if (ivld[0] !== 1'b0) begin bad++; $display("FAIL halt_ivalid got=%b exp=0", ivld[0]); end
  endtask

  task automatic test_store_wait();
    clear_prog();
    imem[0] = {20'h12345, 5'd3, 7'h37};
    imem[1] = e_s(4, 3, 0, 2);
    do_reset();
    dwait = 3;
    run(30);
    total++; if (da[0][0] !== 32'h4) begin bad++; $display("FAIL sw_addr got=%h exp=4", da[0][0]); end
    total++; if (db[0][0] !== 4'hF) begin bad++; $display("FAIL sw_be got=%h exp=f", db[0][0]); end
    total++; if (dw[0][0] !== 32'h1234_5000) begin bad++; $display("FAIL sw_wdata got=%h exp=12345000", dw[0][0]); end
    total++; if (dwr[0][0] !== 1'b1) begin bad++; $display("FAIL sw_we got=%b exp=1", dwr[0][0]); end
    total++; if (rcyc[0][1] - rcyc[0][0] !== 6) begin bad++; $display("FAIL sw_cycles got=%0d exp=6", rcyc[0][1] - rcyc[0][0]); end
  endtask

  task automatic test_byte_ldst();
    clear_prog();
    imem[0] = e_i(32'h80, 0, 0, 3, 7'h13);
    imem[1] = e_s(1, 3, 0, 0);
    imem[2] = e_i(1, 0, 0, 4, 7'h03);
    imem[3] = e_s(8, 4, 0, 2);
    drdata = 32'h0000_8000;
    do_reset();
    run(40);
    total++; if (dn[0] !== 3) begin bad++; $display("FAIL b_ntx got=%0d exp=3", dn[0]); end
    total++; if (db[0][0] !== 4'b0010) begin bad++; $display("FAIL sb_be got=%b exp=0010", db[0][0]); end
    total++; if (dw[0][0] !== 32'h8080_8080) begin bad++; $display("FAIL sb_wdata got=%h exp=80808080", dw[0][0]); end
    total++; if (da[0][0] !== 32'h1) begin bad++; $display("FAIL sb_addr got=%h exp=1", da[0][0]); end
    total++; if (db[0][1] !== 4'b0010) begin bad++; $display("FAIL lb_be got=%b exp=0010", db[0][1]); end
    total++; if (dwr[0][1] !== 1'b0) begin bad++; $display("FAIL lb_we got=%b exp=0", dwr[0][1]); end
    total++; if (dw[0][2] !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_x4 got=%h exp=ffffff80", dw[0][2]); end
  endtask

  task automatic test_branch();
    clear_prog();
    imem[0] = e_i(1, 0, 0, 1, 7'h13);
    imem[1] = e_j(12, 7);
    imem[2] = e_s(0, 7, 0, 2);
    imem[3] = e_i(0, 0, 0, 1, 7'h13);
    imem[4] = e_b(-8, 1, 0, 1);
    imem[5] = e_b(8, 7, 1, 0);
    imem[6] = e_j(8, 0);
    imem[8] = e_s(4, 0, 0, 2);
    drdata = '0;
    do_reset();
    run(60);
    total++; if (fn[0] !== 10) begin bad++; $display("FAIL br_nfetch got=%0d exp=10", fn[0]); end
    total++; if (fa[0][2] !== 32'h10) begin bad++; $display("FAIL jal_tgt got=%h exp=10", fa[0][2]); end
    total++; if (fa[0][3] !== 32'h08) begin bad++; $display("FAIL bne_taken got=%h exp=8", fa[0][3]); end
    total++; if (fa[0][6] !== 32'h14) begin bad++; $display("FAIL bne_fall got=%h exp=14", fa[0][6]); end
    total++; if (fa[0][7] !== 32'h18) begin bad++; $display("FAIL beq_fall got=%h exp=18", fa[0][7]); end
    total++; if (fa[0][8] !== 32'h20) begin bad++; $display("FAIL jalx0_tgt got=%h exp=20", fa[0][8]); end
    total++; if (dw[0][0] !== 32'h8) begin bad++; $display("FAIL jal_link got=%h exp=8", dw[0][0]); end
    total++; if (dw[0][1] !== 32'h0) begin bad++; $display("FAIL x0_kept got=%h exp=0", dw[0][1]); end
  endtask

  task automatic test_misalign();
    clear_prog();
    imem[0] = e_i(9, 0, 0, 5, 7'h13);
    imem[1] = e_i(2, 0, 2, 5, 7'h03);
    imem[2] = e_s(0, 5, 0, 2);
    do_reset();
    run(40);
    total++; if (tc[0] !== 1) begin bad++; $display("FAIL mis_trap0 got=%0d exp=1", tc[0]); end
    total++; if (hlt[0] !== 1'b1) begin bad++; $display("FAIL mis_halt0 got=%b exp=1", hlt[0]); end
    total++; if (dn[0] !== 0) begin bad++; $display("FAIL mis_nodbus got=%0d exp=0", dn[0]); end
    total++; if (rc[0] !== 1) begin bad++; $display("FAIL mis_ret0 got=%0d exp=1", rc[0]); end
    total++; if (tc[1] !== 1) begin bad++; $display("FAIL mis_trap1 got=%0d exp=1", tc[1]); end
    total++; if (dn[1] !== 1) begin bad++; $display("FAIL mis_ntx1 got=%0d exp=1", dn[1]); end
    total++; if (dw[1][0] !== 32'h9) begin bad++; $display("FAIL mis_rd_kept got=%h exp=9", dw[1][0]); end
    total++; if (rc[1] !== 4) begin bad++; $display("FAIL mis_ret1 got=%0d exp=4", rc[1]); end
  endtask

  task automatic test_illegal();
    clear_prog();
    imem[0] = 32'h0000_0000;
    do_reset();
    run(20);
    total++; if (rc[0] !== 0) begin bad++; $display("FAIL ill_ret0 got=%0d exp=0", rc[0]); end
    total++; if (tc[0] !== 1) begin bad++; $display("FAIL ill_trap0 got=%0d exp=1", tc[0]); end
    total++; if (hlt[0] !== 1'b1) begin bad++; $display("FAIL ill_halt0 got=%b exp=1", hlt[0]); end
    total++; if (rc[1] !== 2) begin bad++; $display("FAIL ill_ret1 got=%0d exp=2", rc[1]); end
    total++; if (tc[1] !== 1) begin bad++; $display("FAIL ill_trap1 got=%0d exp=1", tc[1]); end
  endtask

  task automatic test_reset_mid_fetch();
    clear_prog();
    imem[0] = e_i(3, 0, 0, 1, 7'h13);
    imem[1] = e_j(8, 0);
    do_reset();
    iwait = 100;
    run(6);
    total++; if (ivld[0] !== 1'b1) begin bad++; $display("FAIL stall_ivalid got=%b exp=1", ivld[0]); end
    total++; if (fn[0] !== 0) begin bad++; $display("FAIL stall_nfetch got=%0d exp=0", fn[0]); end
    #1 rstn = 1'b0;
    #1;
    total++; if (ivld !== 2'b00) begin bad++; $display("FAIL async_drop got=%b exp=00", ivld); end
    total++; if (iaddr[0] !== 32'h0) begin bad++; $display("FAIL async_pc got=%h exp=0", iaddr[0]); end
    do_reset();
    run(20);
    total++; if (fa[0][0] !== 32'h0) begin bad++; $display("FAIL restart_pc got=%h exp=0", fa[0][0]); end
    total++; if (fa[0][2] !== 32'h0C) begin bad++; $display("FAIL restart_jal got=%h exp=c", fa[0][2]); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_wait();
    test_byte_ldst();
    test_branch();
    test_misalign();
    test_illegal();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
